// File: rtl/full_sub_use_always_ifelse_if.sv
// Operand/result bundle for the registered full subtractor.
// The master drives operands and enable; the slave returns the registered result.
interface full_sub_use_always_ifelse_if #(
    parameter int WIDTH = 1
);
    logic             en;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             borrow_in;
    logic [WIDTH-1:0] Y;
    logic             borrow_out;
    logic             valid;

    modport master (
        output en, A, B, borrow_in,
        input  Y, borrow_out, valid
    );

    modport slave (
        input  en, A, B, borrow_in,
        output Y, borrow_out, valid
    );
endinterface

// File: rtl/full_sub_use_always_ifelse.sv
// Registered, enable-gated ripple-borrow full subtractor: {borrow_out, Y} = A - B - borrow_in.
// Each bit is an explicit if/else decode of {a, b, bi}; outputs update only on enabled edges.
module full_sub_use_always_ifelse #(
    parameter int WIDTH = 1
) (
    input  logic                        clk,
    input  logic                        rst,
    full_sub_use_always_ifelse_if.slave bus
);
    logic [WIDTH-1:0] diff_next;
    logic [WIDTH:0]   borrow_chain;
    logic [1:0]       bit_res;
    logic [WIDTH-1:0] y_reg;
    logic             borrow_reg;
    logic             valid_reg;

    // One-bit subtract cell, returned as {d, bo}.
    function automatic logic [1:0] sub_bit(input logic a, input logic b, input logic bi);
        logic [1:0] r;
        if ({a, b, bi} == 3'b000) begin
            r = 2'b00;
        end else if ({a, b, bi} == 3'b001) begin
            r = 2'b11;
        end else if ({a, b, bi} == 3'b010) begin
            r = 2'b11;
        end else if ({a, b, bi} == 3'b011) begin
            r = 2'b01;
        end else if ({a, b, bi} == 3'b100) begin
            r = 2'b10;
        end else if ({a, b, bi} == 3'b101) begin
            r = 2'b00;
        end else if ({a, b, bi} == 3'b110) begin
            r = 2'b00;
        end else begin
            r = 2'b11;
        end
        return r;
    endfunction

    // The borrow ripples through a single block so the chain is evaluated in bit order.
    always_comb begin
        diff_next       = '0;
        bit_res         = '0;
        borrow_chain    = '0;
        borrow_chain[0] = bus.borrow_in;
        for (int i = 0; i < WIDTH; i++) begin
            bit_res             = sub_bit(bus.A[i], bus.B[i], borrow_chain[i]);
            diff_next[i]        = bit_res[1];
            borrow_chain[i + 1] = bit_res[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            y_reg      <= '0;
            borrow_reg <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            valid_reg <= bus.en;
            if (bus.en) begin
                y_reg      <= diff_next;
                borrow_reg <= borrow_chain[WIDTH];
            end
        end
    end

    assign bus.Y          = y_reg;
    assign bus.borrow_out = borrow_reg;
    assign bus.valid      = valid_reg;
endmodule

// File: tb/tb_full_sub_use_always_ifelse.sv
// Bench for the registered full subtractor: 1-bit and 8-bit instances against an arithmetic model.
module tb_full_sub_use_always_ifelse;
    logic clk;
    logic rst;

    full_sub_use_always_ifelse_if #(.WIDTH(1)) bus1 ();
    full_sub_use_always_ifelse_if #(.WIDTH(8)) bus8 ();

    full_sub_use_always_ifelse #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    full_sub_use_always_ifelse #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected register contents, derived from plain subtraction.
    logic       m_y1, m_bo1, m_v;
    logic [7:0] m_y8;
    logic       m_bo8;

    logic [1:0] tt [8] = '{2'b00, 2'b11, 2'b11, 2'b01, 2'b10, 2'b00, 2'b00, 2'b11};
    logic [4:0] dir_tab [5] = '{5'b00111, 5'b01011, 5'b01101, 5'b10100, 5'b11000};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".y1"},  32'(bus1.Y),          32'(m_y1));
        check({tag, ".bo1"}, 32'(bus1.borrow_out), 32'(m_bo1));
        check({tag, ".v1"},  32'(bus1.valid),      32'(m_v));
        check({tag, ".y8"},  32'(bus8.Y),          32'(m_y8));
        check({tag, ".bo8"}, 32'(bus8.borrow_out), 32'(m_bo8));
        check({tag, ".v8"},  32'(bus8.valid),      32'(m_v));
    endtask

    // Apply one vector to both instances at the falling edge, clock it, then check.
    task automatic step(input string tag, input logic e,
                        input logic a1, input logic b1, input logic bi1,
                        input logic [7:0] a8, input logic [7:0] b8, input logic bi8);
        logic [1:0] r1;
        logic [8:0] r8;
        @(negedge clk);
        bus1.en = e; bus1.A = a1; bus1.B = b1; bus1.borrow_in = bi1;
        bus8.en = e; bus8.A = a8; bus8.B = b8; bus8.borrow_in = bi8;
        @(posedge clk);
        #1;
        r1 = {1'b0, a1} - {1'b0, b1} - {1'b0, bi1};
        r8 = {1'b0, a8} - {1'b0, b8} - {8'b0, bi8};
        if (e) begin
            {m_bo1, m_y1} = r1;
            {m_bo8, m_y8} = r8;
        end
        m_v = e;
        check_all(tag);
        $display("step %s en=%0b A1=%0b B1=%0b bi1=%0b A8=%02h B8=%02h bi8=%0b -> Y1=%0b bo1=%0b Y8=%02h bo8=%0b v=%0b",
                 tag, e, a1, b1, bi1, a8, b8, bi8, bus1.Y, bus1.borrow_out, bus8.Y, bus8.borrow_out, bus1.valid);
    endtask

    initial begin
        logic [4:0] v;
        logic [2:0] idx;
        int         rst_at;

        // Reset is asserted between edges with capture-worthy inputs applied.
        rst = 1'b0;
        bus1.en = 1'b1; bus1.A = 1'b1; bus1.B = 1'b0; bus1.borrow_in = 1'b1;
        bus8.en = 1'b1; bus8.A = 8'h05; bus8.B = 8'h00; bus8.borrow_in = 1'b1;
        #2 rst = 1'b1;
        #1;
        m_y1 = 0; m_bo1 = 0; m_y8 = 0; m_bo8 = 0; m_v = 0;
        check_all("async_rst");
        @(posedge clk); #1;
        check_all("rst_held");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        m_y1 = 1'b0; m_bo1 = 1'b0; m_y8 = 8'h04; m_bo8 = 1'b0; m_v = 1'b1;
        check_all("first_cap");

        // Directed 1-bit vectors against the specified truth-table results.
        for (int k = 0; k < 5; k++) begin
            v = dir_tab[k];
            step("dir", 1'b1, v[4], v[3], v[2], 8'($urandom), 8'($urandom), 1'($urandom));
            check("dir.y_const",  32'(bus1.Y),          32'(v[1]));
            check("dir.bo_const", 32'(bus1.borrow_out), 32'(v[0]));
        end

        // Exhaustive 1-bit truth table.
        for (int k = 0; k < 8; k++) begin
            idx = 3'(k);
            step("exh", 1'b1, idx[2], idx[1], idx[0], 8'($urandom), 8'($urandom), 1'($urandom));
            check("exh.tt", 32'({bus1.Y, bus1.borrow_out}), 32'(tt[k]));
        end

        // Enable hold: result stays, valid drops after one edge.
        step("hold_cap", 1'b1, 1'b1, 1'b0, 1'b0, 8'h10, 8'h01, 1'b0);
        check("hold_cap.y", 32'(bus1.Y), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step("hold", 1'b0, 1'b0, 1'b1, 1'b1, 8'hAA, 8'hFF, 1'b1);
            check("hold.y",  32'(bus1.Y),          32'd1);
            check("hold.bo", 32'(bus1.borrow_out), 32'd0);
            check("hold.y8", 32'(bus8.Y),          32'h0F);
        end

        // 8-bit wrap-around corners.
        step("wrap0", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h01, 1'b1);
        check("wrap0.y8",  32'(bus8.Y),          32'hFE);
        check("wrap0.bo8", 32'(bus8.borrow_out), 32'd1);
        step("wrap1", 1'b1, 1'b0, 1'b0, 1'b0, 8'h80, 8'h7F, 1'b0);
        check("wrap1.y8",  32'(bus8.Y),          32'h01);
        check("wrap1.bo8", 32'(bus8.borrow_out), 32'd0);

        // Random stream with a reset pulse dropped between two edges.
        rst_at = 20;
        for (int k = 0; k < 60; k++) begin
            step("rand", ($urandom_range(0, 3) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom), 1'($urandom));
            if (k == rst_at) begin
                #1 rst = 1'b1;
                #1;
                m_y1 = 0; m_bo1 = 0; m_y8 = 0; m_bo8 = 0; m_v = 0;
                check_all("mid_rst");
                #1 rst = 1'b0;
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/full_sub_use_always_ifelse.md
# full_sub_use_always_ifelse

Registered, enable-gated full subtractor. It computes Y = A − B − borrow_in together with the borrow out, and captures the result on the rising clock edge only when en is high. It serves as the borrow-chain arithmetic primitive in the datapath, parameterised from a single bit up to a multi-bit ripple-borrow subtractor. The 1-bit configuration is the reference behaviour.

## Interface
Parameters:
- WIDTH, default 1: operand and difference width in bits (≥1).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  capture enable; result registered only when high.
- A  input  WIDTH  minuend.
- B  input  WIDTH  subtrahend.
- borrow_in  input  1  borrow into bit 0.
- Y  output  WIDTH  registered difference bits.
- borrow_out  output  1  registered borrow out of the MSB.
- valid  output  1  registered copy of en; high for the cycle after a capture.

## Operation
- Combinational core is a ripple-borrow chain. Bit i has inputs a=A[i], b=B[i], bi (the borrow into that bit):
  - d = a ^ b ^ bi.
  - bo = (~a & b) | (~a & bi) | (b & bi).
  - bi(0) = borrow_in; bi(i+1) = bo(i); borrow_out is taken from bo(WIDTH−1).
- Each bit is written as an explicit if/else decode on {a,b,bi}. For WIDTH=1 the full truth table, as (a,b,bi) → (d,bo), is:
  - 000→00, 001→11, 010→11, 011→01
  - 100→10, 101→00, 110→00, 111→11
- Arithmetic equivalence:
  - {borrow_out, Y} equals the (WIDTH+1)-bit two's-complement result of A − B − borrow_in.
  - Y is that result mod 2^WIDTH.
  - borrow_out = 1 exactly when A < B + borrow_in, treating the operands as unsigned.
- Register update:
  - rst high: Y=0, borrow_out=0, valid=0.
  - Rising clk with en=1: Y, borrow_out ← core result; valid ← 1.
  - Rising clk with en=0: Y and borrow_out hold their previous values; valid ← 0.
  - en, A, B or borrow_in that are X or Z while en=1 are a bench error, and the outputs are don't-care.
- Reset has priority over en.

## Timing
- Latency is one cycle. Inputs are sampled on rising edge N, and the result appears on Y/borrow_out just after edge N.
- Throughput is one operation per cycle. Operands may change every cycle while en stays high.
- Reset is asynchronous. Asserting rst clears all outputs immediately, without waiting for a clock edge, including mid-operation.
- Deassertion of rst must meet recovery/removal timing relative to clk.
  - The first capture is on the first rising edge with rst low and en high.
- When en goes low, Y and borrow_out keep the last captured result indefinitely, and valid drops after one edge.
- Operand changes between edges have no effect on the outputs; there is no combinational path from the inputs to the outputs.
- Critical path is the WIDTH-deep borrow ripple. No pipelining is required at WIDTH ≤ 32.

## Test plan
- Reset: assert rst with en=1, A=1, B=0, borrow_in=1 → Y=0, borrow_out=0, valid=0 while rst is high, with no clock needed; release → values captured on the next edge.
- WIDTH=1 directed sequence, en=1, one vector per cycle, checking (Y, borrow_out) one cycle later:
  - (A,B,bin)=(0,0,1) → (1,1)
  - (0,1,0) → (1,1)
  - (0,1,1) → (0,1)
  - (1,0,1) → (0,0)
  - (1,1,0) → (0,0)
- WIDTH=1 exhaustive: all 8 {A,B,borrow_in} combinations → outputs match the truth table above.
- Enable hold: capture (1,0,0), giving Y=1, bo=0; then en=0 with (0,1,1) applied for 3 cycles → Y=1, bo=0 held; valid=1 then 0.
- WIDTH=8 wrap: A=0x00, B=0x01, borrow_in=1 → Y=0xFE, borrow_out=1.
  - A=0x80, B=0x7F, borrow_in=0 → Y=0x01, borrow_out=0.
- Async reset mid-stream: en=1 with a random vector every cycle; pulse rst between edges → outputs go to 0 before the next edge, and capture resumes after release; a random compare against A − B − borrow_in passes.
